// File: rtl/btle_rx_pdu_streamer_if.sv
// Byte stream from the PDU streamer to the link layer.
// Valid/ready handshake with an end-of-frame flag.
interface btle_rx_pdu_streamer_if;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/btle_rx_pdu_streamer.sv
// Reads each decoded BLE PDU (header + payload) out of the PHY octet memory.
// Emits it as a valid/ready byte stream; frames arriving while busy, or failing CRC, are counted and dropped.
module btle_rx_pdu_streamer #(
    parameter bit DROP_BAD_CRC = 1'b1,
    parameter int MEM_ADDR_W   = 6,
    parameter int CNT_W        = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_decode_end,
    input  logic                   rx_crc_ok,
    input  logic [2:0]             rx_best_phase,
    input  logic [6:0]             rx_payload_length,
    output logic [MEM_ADDR_W-1:0]  rx_pdu_octet_mem_addr,
    input  logic [7:0]             rx_pdu_octet_mem_data,
    btle_rx_pdu_streamer_if.master m_stream,
    output logic                   frame_crc_ok,
    output logic [2:0]             frame_phase,
    output logic [6:0]             frame_nbytes,
    output logic                   busy,
    output logic [CNT_W-1:0]       drop_busy_cnt,
    output logic [CNT_W-1:0]       drop_crc_cnt
);
    localparam logic [8:0] DEPTH = 9'(2 ** MEM_ADDR_W);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_HOLD} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [MEM_ADDR_W-1:0] r_addr;
    logic [MEM_ADDR_W-1:0] r_last_idx;
    logic [7:0]            r_data;
    logic                  r_last;
    logic                  r_crc_ok;
    logic [2:0]            r_phase;
    logic [6:0]            r_nbytes;
    logic [CNT_W-1:0]      r_drop_busy;
    logic [CNT_W-1:0]      r_drop_crc;

    logic [7:0]            w_len_plus2;
    logic [6:0]            w_nbytes;
    logic                  w_crc_reject;
    logic                  w_accept;
    logic                  w_handshake;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Header is 2 octets; a frame can never be longer than the octet memory.
    always_comb begin
        w_len_plus2  = {1'b0, rx_payload_length} + 8'd2;
        w_nbytes     = ({1'b0, w_len_plus2} > DEPTH) ? DEPTH[6:0] : w_len_plus2[6:0];
        w_crc_reject = DROP_BAD_CRC && !rx_crc_ok;
        w_accept     = rx_decode_end && (r_state == S_IDLE) && !w_crc_reject;
        w_handshake  = (r_state == S_HOLD) && m_stream.m_ready;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_FETCH;
            S_FETCH: w_state_nxt = S_WAIT;
            S_WAIT:  w_state_nxt = S_HOLD;
            S_HOLD:  if (w_handshake) w_state_nxt = r_last ? S_IDLE : S_FETCH;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        m_stream.m_valid = (r_state == S_HOLD);
        m_stream.m_last  = (r_state == S_HOLD) && r_last;
        m_stream.m_data  = r_data;
        busy             = (r_state != S_IDLE);
    end

    assign rx_pdu_octet_mem_addr = r_addr;
    assign frame_crc_ok          = r_crc_ok;
    assign frame_phase           = r_phase;
    assign frame_nbytes          = r_nbytes;
    assign drop_busy_cnt         = r_drop_busy;
    assign drop_crc_cnt          = r_drop_crc;

    // Memory read data is valid in WAIT, one cycle after the address was presented in FETCH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr     <= '0;
            r_last_idx <= '0;
            r_data     <= '0;
            r_last     <= 1'b0;
            r_crc_ok   <= 1'b0;
            r_phase    <= '0;
            r_nbytes   <= '0;
        end else begin
            if (w_accept) begin
                r_crc_ok   <= rx_crc_ok;
                r_phase    <= rx_best_phase;
                r_nbytes   <= w_nbytes;
                r_last_idx <= MEM_ADDR_W'(w_nbytes - 7'd1);
                r_addr     <= '0;
            end
            if (r_state == S_WAIT) begin
                r_data <= rx_pdu_octet_mem_data;
                r_last <= (r_addr == r_last_idx);
            end
            if (w_handshake && !r_last) begin
                r_addr <= r_addr + MEM_ADDR_W'(1);
            end
        end
    end

    // A decode_end on the final-handshake cycle still sees a non-idle state and is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drop_busy <= '0;
            r_drop_crc  <= '0;
        end else if (rx_decode_end) begin
            if (r_state != S_IDLE) begin
                r_drop_busy <= sat_inc(r_drop_busy);
            end else if (w_crc_reject) begin
                r_drop_crc <= sat_inc(r_drop_crc);
            end
        end
    end
endmodule

// File: tb/tb_btle_rx_pdu_streamer.sv
// Randomised and directed bench for btle_rx_pdu_streamer against a transaction-level reference model.
// A second instance with bad-CRC dropping disabled covers the streamed-bad-CRC case.
module tb_btle_rx_pdu_streamer;
    logic       clk;
    logic       rst;
    logic       de;
    logic       crc;
    logic [2:0] ph;
    logic [6:0] len;
    logic       r_ready;
    logic [5:0] addr0, addr1;
    logic [7:0] md0, md1;
    logic       fcrc0, fcrc1, busy0, busy1;
    logic [2:0] fph0, fph1;
    logic [6:0] fn0, fn1;
    logic [7:0] dbusy0, dcrc0, dbusy1, dcrc1;
    logic [7:0] mem [64];

    int errors = 0;
    int checks = 0;
    int got[$];
    int cnt1 = 0;

    btle_rx_pdu_streamer_if s0();
    btle_rx_pdu_streamer_if s1();
    assign s0.m_ready = r_ready;
    assign s1.m_ready = 1'b1;

    btle_rx_pdu_streamer #(.DROP_BAD_CRC(1'b1), .MEM_ADDR_W(6), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .rx_decode_end(de), .rx_crc_ok(crc), .rx_best_phase(ph),
        .rx_payload_length(len), .rx_pdu_octet_mem_addr(addr0), .rx_pdu_octet_mem_data(md0),
        .m_stream(s0), .frame_crc_ok(fcrc0), .frame_phase(fph0), .frame_nbytes(fn0),
        .busy(busy0), .drop_busy_cnt(dbusy0), .drop_crc_cnt(dcrc0));

    btle_rx_pdu_streamer #(.DROP_BAD_CRC(1'b0), .MEM_ADDR_W(6), .CNT_W(8)) dut_keep (
        .clk(clk), .rst(rst), .rx_decode_end(de), .rx_crc_ok(crc), .rx_best_phase(ph),
        .rx_payload_length(len), .rx_pdu_octet_mem_addr(addr1), .rx_pdu_octet_mem_data(md1),
        .m_stream(s1), .frame_crc_ok(fcrc1), .frame_phase(fph1), .frame_nbytes(fn1),
        .busy(busy1), .drop_busy_cnt(dbusy1), .drop_crc_cnt(dcrc1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // registered-read PDU memory
    initial begin
        forever begin
            @(posedge clk);
            md0 <= mem[addr0];
            md1 <= mem[addr1];
        end
    end

    // Reference model: frame-level bookkeeping with a 3-cycle fetch latency per byte.
    bit         e_busy = 0, e_vld = 0, e_crc = 0;
    int         e_cnt = 0, e_idx = 0, e_n = 0, e_dbusy = 0, e_dcrc = 0;
    logic [2:0] e_ph = 3'd0;

    function automatic int sat8(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    initial begin
        bit was_busy;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                e_busy = 0; e_vld = 0; e_crc = 0; e_cnt = 0; e_idx = 0; e_n = 0;
                e_dbusy = 0; e_dcrc = 0; e_ph = 3'd0;
            end else begin
                was_busy = e_busy;
                if (e_busy) begin
                    if (e_vld) begin
                        if (r_ready) begin
                            e_vld = 0;
                            if (e_idx == e_n - 1) e_busy = 0;
                            else begin e_idx++; e_cnt = 2; end
                        end
                    end else begin
                        e_cnt--;
                        if (e_cnt == 0) e_vld = 1;
                    end
                end
                if (de) begin
                    if (was_busy) e_dbusy = sat8(e_dbusy);
                    else if (!crc) e_dcrc = sat8(e_dcrc);
                    else begin
                        e_busy = 1; e_vld = 0; e_cnt = 2; e_idx = 0;
                        e_n = (int'(len) + 2 > 64) ? 64 : int'(len) + 2;
                        e_crc = crc; e_ph = ph;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // compare DUT against model every cycle, plus handshake monitors
    initial begin
        logic [31:0] ea, aa;
        forever begin
            @(negedge clk);
            ea = {22'd0, e_vld, e_vld && (e_idx == e_n - 1), e_vld ? mem[e_idx] : 8'h00};
            aa = {22'd0, s0.m_valid, s0.m_last, s0.m_valid ? s0.m_data : 8'h00};
            chk("stream", aa, ea);
            chk("status", {25'd0, busy0, addr0}, {25'd0, e_busy, 6'(e_idx)});
            chk("frame", {21'd0, fcrc0, fph0, fn0}, {21'd0, e_crc, e_ph, 7'(e_n)});
            chk("counters", {16'd0, dbusy0, dcrc0}, {16'd0, 8'(e_dbusy), 8'(e_dcrc)});
            if (rst && s0.m_valid && r_ready)
                got.push_back((int'(addr0) << 9) | (int'(s0.m_last) << 8) | int'(s0.m_data));
            if (rst && s1.m_valid) cnt1++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic c, input logic [2:0] p, input logic [6:0] l);
        de = 1'b1; crc = c; ph = p; len = l;
        step();
        de = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max);
        bit ok;
        ok = 0;
        for (int j = 0; j < max; j++) begin
            if (!busy0 && !busy1) begin ok = 1; break; end
            step();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: still busy after %0d cycles, required idle", name, max);
        end
    endtask

    // frames use mem[i]=i, so byte i must carry data i at address i
    task automatic check_seq(input string tag, input int n);
        chk({tag, "_count"}, got.size(), n);
        for (int i = 0; i < got.size() && i < n; i++) begin
            chk({tag, "_data"}, got[i] & 255, i);
            chk({tag, "_addr"}, got[i] >> 9, i);
            chk({tag, "_last"}, (got[i] >> 8) & 1, (i == n - 1) ? 1 : 0);
        end
        got.delete();
    endtask

    initial begin
        int k;
        bit ok;
        rst = 1'b0; de = 1'b0; crc = 1'b0; ph = 3'd0; len = 7'd0; r_ready = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 8'(i);
        repeat (3) step();
        chk("rst_valid", s0.m_valid, 0);
        chk("rst_addr", addr0, 0);
        rst = 1'b1;
        step();
        chk("rst_busy", busy0, 0);
        chk("rst_cnts", {dbusy0, dcrc0}, 0);

        // basic frame, ready held high, latency measurement
        r_ready = 1'b1;
        de = 1'b1; crc = 1'b1; ph = 3'd5; len = 7'd5; k = 0;
        for (int j = 0; j < 10; j++) begin
            step(); de = 1'b0; k++;
            if (s0.m_valid) break;
        end
        chk("t1_latency", k, 3);
        chk("t1_phase", fph0, 5);
        wait_idle("t1_idle", 100);
        chk("t1_busy", busy0, 0);
        check_seq("t1", 7);

        // same frame with consumer accepting one cycle in three
        pulse(1'b1, 3'd2, 7'd5);
        ok = 0;
        for (int j = 0; j < 300; j++) begin
            r_ready = (j % 3 == 0);
            step();
            if (!busy0 && !busy1) begin ok = 1; break; end
        end
        chk("t2_done", ok, 1);
        r_ready = 1'b1;
        check_seq("t2", 7);

        // bad CRC: dropped by one instance, streamed by the other
        cnt1 = 0;
        pulse(1'b0, 3'd1, 7'd5);
        repeat (20) step();
        wait_idle("t3_idle", 100);
        chk("t3_drop_crc", dcrc0, 1);
        chk("t3_no_stream", got.size(), 0);
        chk("t3_keep_count", cnt1, 7);
        chk("t3_keep_crc", fcrc1, 0);
        chk("t3_keep_dropcnt", dcrc1, 0);

        // oversized payload clamps to the memory depth
        pulse(1'b1, 3'd3, 7'd100);
        chk("t4_nbytes", fn0, 64);
        chk("t4_model_n", e_n, 64);
        wait_idle("t4_idle", 400);
        check_seq("t4", 64);

        // second frame while stalled is dropped, first completes
        r_ready = 1'b0;
        pulse(1'b1, 3'd4, 7'd3);
        repeat (5) step();
        pulse(1'b1, 3'd6, 7'd10);
        chk("t5_drop_busy", dbusy0, 1);
        chk("t5_phase_kept", fph0, 4);
        r_ready = 1'b1;
        wait_idle("t5_idle", 100);
        check_seq("t5", 5);

        // reset during a stalled byte
        r_ready = 1'b0;
        pulse(1'b1, 3'd0, 7'd4);
        repeat (4) step();
        chk("t6_pre_valid", s0.m_valid, 1);
        rst = 1'b0;
        #1;
        chk("t6_valid", s0.m_valid, 0);
        chk("t6_last", s0.m_last, 0);
        chk("t6_busy", busy0, 0);
        chk("t6_cnts", {dbusy0, dcrc0}, 0);
        step();
        rst = 1'b1;
        step();
        got.delete();
        r_ready = 1'b1;
        pulse(1'b1, 3'd7, 7'd2);
        wait_idle("t6_idle", 100);
        check_seq("t6", 4);

        // counter saturation
        r_ready = 1'b0;
        pulse(1'b1, 3'd1, 7'd5);
        for (int j = 0; j < 300; j++) begin
            de = 1'b1; crc = 1'b1; step(); de = 1'b0; step();
        end
        chk("t7_busy_sat", dbusy0, 255);
        chk("t7_model_sat", e_dbusy, 255);
        r_ready = 1'b1;
        wait_idle("t7_idle", 300);
        got.delete();
        for (int j = 0; j < 300; j++) begin
            de = 1'b1; crc = 1'b0; len = 7'd0; step(); de = 1'b0; step();
        end
        chk("t7_crc_sat", dcrc0, 255);
        chk("t7_no_stream", got.size(), 0);
        wait_idle("t7_idle2", 100);

        // randomised traffic against the model
        rst = 1'b0;
        step(); step();
        rst = 1'b1;
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom_range(0, 255));
        step();
        for (int j = 0; j < 4000; j++) begin
            de      = !de && ($urandom_range(0, 29) == 0);
            crc     = ($urandom_range(0, 3) != 0);
            len     = 7'($urandom_range(0, 127));
            ph      = 3'($urandom_range(0, 7));
            r_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        de = 1'b0;
        r_ready = 1'b1;
        wait_idle("t8_idle", 600);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
